clken_fracdiv_multi: RTL and testbench
======================================

Name: clken_fracdiv_multi

Overview:
- Multi-channel fractional clock-enable generator in the system clock domain.
- Runs downstream of the board PLL, so lower-rate domains (timers, audio, SD card, video pixel enable) share one fabric clock and use strobes instead of extra PLL outputs.
- Qualifies the raw PLL lock with a synchroniser and a stability counter.
- Produces per-channel enable strobes at runtime-programmable rates, plus per-channel domain resets sequenced from lock.

Parameters:
- CHANNELS, 3, number of independent strobe channels (1..8).
- ACC_WIDTH, 24, phase accumulator width. Strobe rate = f_clock * inc / 2^ACC_WIDTH.
- LOCK_STABLE, 1024, consecutive synchronised-lock cycles required before RUN (>=2).
- DEFAULT_INC, {CHANNELS{24'h200000}}, packed CHANNELS*ACC_WIDTH reset increments. Channel 0 occupies the LSBs.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- pll_locked  in  1  raw PLL LOCK, asynchronous.
- cfg_wr  in  1  single-cycle increment write strobe.
- cfg_sel  in  max(1,$clog2(CHANNELS))  channel index.
- cfg_inc  in  ACC_WIDTH  new increment.
- cfg_ack  out  1  write-accepted pulse.
- ch_enable  in  CHANNELS  per-channel run enable.
- strobe  out  CHANNELS  one-cycle enable pulses.
- domain_reset  out  CHANNELS  per-channel active-high reset.
- ready  out  1  lock qualified; high only in RUN.

Behaviour:
- Reset values:
  - strobe=0, cfg_ack=0, ready=0, domain_reset=all 1.
  - FSM=WAIT_LOCK, stability counter=0, synchroniser=0, accumulators=0.
  - Increments=DEFAULT_INC.
- Lock synchroniser: 2 flip-flops; lock_s is the second stage.
- FSM:
  - WAIT_LOCK: counter=0. If lock_s=1, go to STABLE.
  - STABLE: counter increments each cycle. If lock_s=0, go to WAIT_LOCK and clear the counter. When counter==LOCK_STABLE-1 with lock_s=1, go to RUN.
  - RUN: ready=1 (registered, so it rises the cycle RUN is entered). If lock_s=0, go to WAIT_LOCK.
  - On the exit from RUN, the same edge sets ready=0, strobe=0, domain_reset=all 1, and clears all accumulators.
- Latency: pll_locked rising to ready=1 takes exactly LOCK_STABLE+3 clock edges.
- Accumulator, per channel, only while in RUN with ch_enable[i]=1:
  - {carry,acc} = acc + inc, computed ACC_WIDTH+1 bits wide.
  - strobe[i] <= carry. The strobe is registered, one cycle after the wrap.
  - inc=0: strobe never fires.
  - inc=2^ACC_WIDTH-1: strobe fires every cycle except one per 2^ACC_WIDTH cycles.
  - With ch_enable[i]=0 or outside RUN: acc held at 0, strobe[i]=0.
- domain_reset[i]:
  - Deasserts on the cycle strobe[i] first asserts in RUN.
  - Then stays 0 until the FSM leaves RUN or reset asserts.
  - Dropping ch_enable[i] does not reassert it.
- Config writes:
  - Accepted in any FSM state.
  - With cfg_wr=1 and cfg_sel<CHANNELS, inc[cfg_sel] updates at the next edge and cfg_ack pulses 1 cycle on that edge.
  - The accumulation in the write cycle uses the old inc.
  - The accumulator is not cleared, so phase continues glitch-free.
  - cfg_sel>=CHANNELS: the write is ignored and there is no ack.
  - Increments persist across lock loss; only reset restores DEFAULT_INC.
- Simultaneous events:
  - reset overrides everything.
  - Lock loss and a cfg_wr in the same cycle: the write still applies.

Optional Feature:
- Macro: CLKEN_SQUARE_EN.
- When defined: adds output port square [CHANNELS] = registered acc[ACC_WIDTH-1] of each channel. This gives a roughly 50% duty clock-like signal, 0 whenever the channel is idle, reset value 0.
- When not defined: the port and its registers are absent; all other behaviour is identical.

Decomposition:
- Package clken_pkg holds:
  - the FSM state enum (WAIT_LOCK, STABLE, RUN);
  - SYNC_STAGES=2;
  - a function computing inc from a target frequency and the clock frequency (used by the bench and by integrators).
- Sub-module clken_accum_ch contains the accumulator, the increment register, the strobe register and the domain_reset flop for one channel. It is instantiated CHANNELS times in a generate loop. The FSM and synchroniser stay in the top module.

Test Plan:
Bench parameters: CHANNELS=3, ACC_WIDTH=8, LOCK_STABLE=16, DEFAULT_INC={8'd64,8'd128,8'd3}.
- Lock-up latency: release reset, hold pll_locked=1 from edge 0 -> ready=0 through edge 18, ready=1 at edge 19. All domain_reset=1 until each channel's first strobe.
- Rates: after RUN, 1024 cycles with all ch_enable=1 -> ch0 (inc 3) gives 12 strobes; ch1 (inc 128) gives 512 strobes at spacing 2; ch2 (inc 64) gives 256 strobes at spacing 4.
- Lock glitch: in RUN, drive pll_locked=0 for 1 cycle -> 3 edges later ready=0, strobe=0, domain_reset=3'b111. Ready returns exactly 19 edges after pll_locked rises again.
- Stability abort: pll_locked drops at STABLE count 10 -> counter clears and ready stays 0. RUN is reached only after 16 uninterrupted lock_s cycles.
- Config writes:
  - cfg_wr, cfg_sel=1, cfg_inc=32 mid-run -> cfg_ack exactly 1 cycle later and ch1 strobe spacing changes from 2 to 8.
  - cfg_sel=3 -> no ack and no increment changes.
- Channel disable: ch_enable[2]=0 from reset -> strobe[2] never fires and domain_reset[2] stays 1. Set ch_enable[2]=1 -> first strobe after 4 cycles, then domain_reset[2]=0.

Source files
------------

// File: rtl/clken_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
// Holds the lock FSM encoding, synchroniser depth and increment calculation.
package clken_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    RUN
  } state_t;

  localparam int SYNC_STAGES = 2;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Strobe rate = f_clock * inc / 2^acc_width, so inc = f_target * 2^acc_width / f_clock.
  function automatic longint unsigned calc_inc(input longint unsigned f_target,
                                               input longint unsigned f_clock,
                                               input int acc_width);
    return (f_target << acc_width) / f_clock;
  endfunction

endpackage

// File: rtl/clken_accum_ch.sv
// One strobe channel: increment register, phase accumulator, strobe and domain reset.
// Strobe is registered one cycle after the wrap; square output only with CLKEN_SQUARE_EN.
module clken_accum_ch #(
  parameter int                   ACC_WIDTH   = 24,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = 24'h200000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 enable,
  input  logic                 wr,
  input  logic [ACC_WIDTH-1:0] wr_inc,
`ifdef CLKEN_SQUARE_EN
  output logic                 square,
`endif
  output logic                 strobe,
  output logic                 domain_reset
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] inc;
  logic [ACC_WIDTH:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge clock) begin
    if (reset) begin
      inc          <= DEFAULT_INC;
      acc          <= '0;
      strobe       <= 1'b0;
      domain_reset <= 1'b1;
    end else begin
      // Increment changes never touch the accumulator, so the phase stays continuous.
      if (wr) inc <= wr_inc;
      if (!run) begin
        acc          <= '0;
        strobe       <= 1'b0;
        domain_reset <= 1'b1;
      end else if (!enable) begin
        acc    <= '0;
        strobe <= 1'b0;
      end else begin
        acc    <= sum[ACC_WIDTH-1:0];
        strobe <= sum[ACC_WIDTH];
        if (sum[ACC_WIDTH]) domain_reset <= 1'b0;
      end
    end
  end

`ifdef CLKEN_SQUARE_EN
  assign square = acc[ACC_WIDTH-1];
`endif

endmodule

// File: rtl/clken_fracdiv_multi.sv
// Multi-channel fractional clock-enable generator with PLL lock qualification.
// ready follows pll_locked by LOCK_STABLE+3 edges; CLKEN_SQUARE_EN adds the square outputs.
module clken_fracdiv_multi
  import clken_pkg::*;
#(
  parameter int                            CHANNELS    = 3,
  parameter int                            ACC_WIDTH   = 24,
  parameter int                            LOCK_STABLE = 1024,
  parameter logic [CHANNELS*ACC_WIDTH-1:0] DEFAULT_INC = {CHANNELS{24'h200000}}
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           pll_locked,
  input  logic                           cfg_wr,
  input  logic [sel_width(CHANNELS)-1:0] cfg_sel,
  input  logic [ACC_WIDTH-1:0]           cfg_inc,
  output logic                           cfg_ack,
  input  logic [CHANNELS-1:0]            ch_enable,
  output logic [CHANNELS-1:0]            strobe,
  output logic [CHANNELS-1:0]            domain_reset,
`ifdef CLKEN_SQUARE_EN
  output logic [CHANNELS-1:0]            square,
`endif
  output logic                           ready
);

  localparam int              SELW      = sel_width(CHANNELS);
  localparam int              CW        = $clog2(LOCK_STABLE);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [SELW:0]   SEL_LIMIT = (SELW + 1)'(CHANNELS);

  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;
  state_t                 state, next_state;
  logic [CW-1:0]          cnt, cnt_next;
  logic                   run_en;

  assign lock_s = sync[SYNC_STAGES-1];

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      WAIT_LOCK: begin
        cnt_next = '0;
        if (lock_s) next_state = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          next_state = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          next_state = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RUN: begin
        cnt_next = '0;
        if (!lock_s) next_state = WAIT_LOCK;
      end
      default: begin
        next_state = WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync    <= '0;
      state   <= WAIT_LOCK;
      cnt     <= '0;
      ready   <= 1'b0;
      cfg_ack <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], pll_locked};
      state   <= next_state;
      cnt     <= cnt_next;
      ready   <= (next_state == RUN);
      cfg_ack <= cfg_wr && ({1'b0, cfg_sel} < SEL_LIMIT);
    end
  end

  // Channels only accumulate while RUN persists; the edge that leaves RUN clears them.
  assign run_en = (state == RUN) && lock_s;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    clken_accum_ch #(
      .ACC_WIDTH  (ACC_WIDTH),
      .DEFAULT_INC(DEFAULT_INC[i*ACC_WIDTH +: ACC_WIDTH])
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .run         (run_en),
      .enable      (ch_enable[i]),
      .wr          (cfg_wr && (cfg_sel == SELW'(i))),
      .wr_inc      (cfg_inc),
`ifdef CLKEN_SQUARE_EN
      .square      (square[i]),
`endif
      .strobe      (strobe[i]),
      .domain_reset(domain_reset[i])
    );
  end

endmodule

// File: tb/tb_clken_fracdiv_multi.sv
// Scoreboard bench: stimulus queues expected output events, the monitor pops them as the DUT shows them.
module tb_clken_fracdiv_multi;
  import clken_pkg::*;

  localparam int CH = 3;
  localparam int AW = 8;
  localparam int LS = 16;
  localparam logic [AW-1:0]    INC2 = AW'(calc_inc(64'd25, 64'd100, AW));
  localparam logic [CH*AW-1:0] DEF  = {INC2, 8'd128, 8'd3};

  logic          clock;
  logic          reset;
  logic          pll_locked;
  logic          cfg_wr;
  logic [1:0]    cfg_sel;
  logic [AW-1:0] cfg_inc;
  logic          cfg_ack;
  logic [CH-1:0] ch_enable;
  logic [CH-1:0] strobe;
  logic [CH-1:0] domain_reset;
  logic          ready;

  clken_fracdiv_multi #(
    .CHANNELS(CH), .ACC_WIDTH(AW), .LOCK_STABLE(LS), .DEFAULT_INC(DEF)
  ) dut (
    .clock(clock), .reset(reset), .pll_locked(pll_locked),
    .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_inc(cfg_inc), .cfg_ack(cfg_ack),
    .ch_enable(ch_enable), .strobe(strobe), .domain_reset(domain_reset), .ready(ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic         rdy;
    logic [CH-1:0] stb;
    logic [CH-1:0] drst;
    logic         ack;
  } snap_t;

  // Event signals: 0-2 strobe[i], 3-5 domain_reset[i] change, 6 ready change, 7 cfg_ack pulse.
  int    expq[8][$];
  snap_t snapq[$];
  int    errors = 0;
  int    checks = 0;
  bit    done   = 1'b0;
  logic [7:0] prev = '0;

  function automatic string sname(input int s);
    case (s)
      0: return "strobe0";
      1: return "strobe1";
      2: return "strobe2";
      3: return "domain_reset0";
      4: return "domain_reset1";
      5: return "domain_reset2";
      6: return "ready";
      default: return "cfg_ack";
    endcase
  endfunction

  task automatic push(input int s, input int c, input bit v);
    expq[s].push_back(c * 2 + int'(v));
  endtask

  task automatic snap(input int c, input logic r, input logic [CH-1:0] st,
                      input logic [CH-1:0] dr, input logic a);
    snap_t e;
    e.cyc = c; e.rdy = r; e.stb = st; e.drst = dr; e.ack = a;
    snapq.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  // Monitor and checker
  always @(negedge clock) begin
    logic [7:0] cur;
    cur = {cfg_ack, ready, domain_reset, strobe};
    if (cyc >= 4) begin
      for (int s = 0; s < 8; s++) begin
        logic ev;
        int   e;
        ev = (s < 3 || s == 7) ? cur[s] : (cur[s] != prev[s]);
        if (ev) begin
          checks++;
          if (expq[s].size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event at cycle %0d value %0b, required no event", sname(s), cyc, cur[s]);
          end else begin
            e = expq[s].pop_front();
            if (e != cyc * 2 + int'(cur[s])) begin
              errors++;
              $display("FAIL %s: event at cycle %0d value %0b, required cycle %0d value %0d",
                       sname(s), cyc, cur[s], e / 2, e % 2);
            end
          end
        end
      end
    end
    prev = cur;
    while (snapq.size() > 0 && snapq[0].cyc <= cyc) begin
      snap_t e;
      e = snapq.pop_front();
      checks++;
      if (e.cyc != cyc || ready !== e.rdy || strobe !== e.stb || domain_reset !== e.drst || cfg_ack !== e.ack) begin
        errors++;
        $display("FAIL snapshot@%0d: cycle=%0d ready=%0b strobe=%b domain_reset=%b cfg_ack=%0b, required ready=%0b strobe=%b domain_reset=%b cfg_ack=%0b",
                 e.cyc, cyc, ready, strobe, domain_reset, cfg_ack, e.rdy, e.stb, e.drst, e.ack);
      end
    end
    if (done) begin
      for (int s = 0; s < 8; s++) begin
        checks++;
        if (expq[s].size() != 0) begin
          errors++;
          $display("FAIL %s: %0d expected events never seen, first at cycle %0d, required 0 pending",
                   sname(s), expq[s].size(), expq[s][0] / 2);
        end
      end
      checks++;
      if (snapq.size() != 0) begin
        errors++;
        $display("FAIL snapshots: %0d pending, required 0", snapq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    int n0, r, g, x, r2, g2, x2, p, d, r3, endc;
    int ch0_k[12];
    ch0_k = '{86, 171, 256, 342, 427, 512, 598, 683, 768, 854, 939, 1024};

    reset = 1'b1; pll_locked = 1'b0; cfg_wr = 1'b0; cfg_sel = '0; cfg_inc = '0;
    ch_enable = 3'b011;

    n0   = 3;          // reset released and lock raised at this negedge
    r    = n0 + 19;    // LOCK_STABLE+3 edges later
    g    = r + 1097;   // one-cycle lock glitch
    x    = g + 3;
    r2   = g + 20;
    g2   = r2 + 30;    // sustained lock loss
    x2   = g2 + 3;
    p    = x2 + 5;     // lock returns, STABLE entered at p+3
    d    = p + 13;     // drop at STABLE count 10
    r3   = d + 20;
    endc = r3 + 50;

    // First RUN window: ch0/ch1 from r, ch2 enabled later, ch1 rate change mid-run
    foreach (ch0_k[k]) push(0, r + ch0_k[k], 1'b1);
    for (int j = 1; j <= 514; j++) push(1, r + 2 * j, 1'b1);
    for (int k = 0; k < 8; k++)    push(1, r + 1036 + 8 * k, 1'b1);
    for (int k = 0; k <= 271; k++) push(2, r + 12 + 4 * k, 1'b1);
    // Second RUN window: ch1 keeps inc 32 across lock loss
    for (int k = 1; k <= 4; k++)   push(1, r2 + 8 * k, 1'b1);
    for (int k = 1; k <= 8; k++)   push(2, r2 + 4 * k, 1'b1);
    // Third RUN window after the aborted qualification
    for (int k = 1; k <= 6; k++)   push(1, r3 + 8 * k, 1'b1);
    for (int k = 1; k <= 12; k++)  push(2, r3 + 4 * k, 1'b1);

    push(3, r + 86, 1'b0);  push(3, x, 1'b1);
    push(4, r + 2, 1'b0);   push(4, x, 1'b1); push(4, r2 + 8, 1'b0); push(4, x2, 1'b1); push(4, r3 + 8, 1'b0);
    push(5, r + 12, 1'b0);  push(5, x, 1'b1); push(5, r2 + 4, 1'b0); push(5, x2, 1'b1); push(5, r3 + 4, 1'b0);
    push(6, r, 1'b1); push(6, x, 1'b0); push(6, r2, 1'b1); push(6, x2, 1'b0); push(6, r3, 1'b1);
    push(7, r + 1028, 1'b1);

    snap(n0,       1'b0, 3'b000, 3'b111, 1'b0);
    snap(r - 1,    1'b0, 3'b000, 3'b111, 1'b0);
    snap(r + 1,    1'b1, 3'b000, 3'b111, 1'b0);
    snap(r + 1028, 1'b1, 3'b110, 3'b000, 1'b1);
    snap(x,        1'b0, 3'b000, 3'b111, 1'b0);
    snap(p + 19,   1'b0, 3'b000, 3'b111, 1'b0);

    wait_until(n0);
    reset = 1'b0; pll_locked = 1'b1;
    wait_until(r + 8);
    ch_enable = 3'b111;
    wait_until(r + 1017);
    cfg_wr = 1'b1; cfg_sel = 2'd3; cfg_inc = 8'd5;
    wait_until(r + 1018);
    cfg_wr = 1'b0;
    wait_until(r + 1027);
    cfg_wr = 1'b1; cfg_sel = 2'd1; cfg_inc = 8'd32;
    wait_until(r + 1028);
    cfg_wr = 1'b0;
    wait_until(g);
    pll_locked = 1'b0;
    wait_until(g + 1);
    pll_locked = 1'b1;
    wait_until(g2);
    pll_locked = 1'b0;
    wait_until(p);
    pll_locked = 1'b1;
    wait_until(d);
    pll_locked = 1'b0;
    wait_until(d + 1);
    pll_locked = 1'b1;
    wait_until(endc + 1);
    done = 1'b1;
  end

endmodule
